// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: widths, opcodes, FSM encoding,
// instruction field layout and status-flag bit indices.
package alu_seq_pkg;

    localparam int unsigned DATA_W    = 4;
    localparam int unsigned REG_COUNT = 4;
    localparam int unsigned RIDX_W    = $clog2(REG_COUNT);
    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned IMM_W     = 4;
    localparam int unsigned FLAG_W    = 4;

    localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
    localparam logic [OP_W-1:0] OP_AND = 4'b0001;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0010;
    localparam logic [OP_W-1:0] OP_NOT = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
    localparam logic [OP_W-1:0] OP_SHL = 4'b0101;
    localparam logic [OP_W-1:0] OP_ASR = 4'b0110;
    localparam logic [OP_W-1:0] OP_SHR = 4'b0111;
    localparam logic [OP_W-1:0] OP_ADD = 4'b1000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b1001;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_WB     = 2'd3;

    localparam int unsigned OP_LSB      = 12;
    localparam int unsigned RD_LSB      = 10;
    localparam int unsigned RS1_LSB     = 8;
    localparam int unsigned RS2_LSB     = 6;
    localparam int unsigned USE_IMM_BIT = 5;
    localparam int unsigned CIN_SEL_BIT = 4;
    localparam int unsigned IMM_LSB     = 0;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [RIDX_W-1:0] rd;
        logic [RIDX_W-1:0] rs1;
        logic [RIDX_W-1:0] rs2;
        logic              use_imm;
        logic              cin_sel;
        logic [IMM_W-1:0]  imm;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
        instr_t d;
        d.op      = raw[OP_LSB +: OP_W];
        d.rd      = raw[RD_LSB +: RIDX_W];
        d.rs1     = raw[RS1_LSB +: RIDX_W];
        d.rs2     = raw[RS2_LSB +: RIDX_W];
        d.use_imm = raw[USE_IMM_BIT];
        d.cin_sel = raw[CIN_SEL_BIT];
        d.imm     = raw[IMM_LSB +: IMM_W];
        return d;
    endfunction

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        case (op)
            OP_NOP, OP_AND, OP_OR, OP_NOT, OP_XOR,
            OP_SHL, OP_ASR, OP_SHR, OP_ADD, OP_SUB: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Sequencer register file: one write port, three combinational read ports.
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RIDX_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RIDX_W-1:0] raddr1,
    input  logic [RIDX_W-1:0] raddr2,
    input  logic [RIDX_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [REG_COUNT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1   = mem[raddr1];
    assign rdata2   = mem[raddr2];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU control: IDLE -> DECODE -> EXEC -> WB, one instruction per 4 cycles.
// Optional retire/illegal counters are enabled with ALU_SEQ_PERF_CNT_EN.
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [OP_W-1:0]    alu_op,
    output logic               alu_cin,
    input  logic [DATA_W-1:0]  alu_y,
    input  logic               alu_n,
    input  logic               alu_z,
    input  logic               alu_c,
    input  logic               alu_v,
    output logic               done,
    output logic               illegal,
    output logic [FLAG_W-1:0]  flags,
`ifdef ALU_SEQ_PERF_CNT_EN
    output logic [15:0]        retired_cnt,
    output logic [7:0]         illegal_cnt,
`endif
    input  logic [RIDX_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    instr_t            instr_q;
    logic [DATA_W-1:0] cap_y;
    logic [FLAG_W-1:0] cap_flags;
    logic              rf_we;
    logic              done_nxt;
    logic              illegal_nxt;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    assign instr_ready = (state == ST_IDLE);

    alu_seq_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (instr_q.rd),
        .wdata    (cap_y),
        .raddr1   (instr_q.rs1),
        .raddr2   (instr_q.rs2),
        .dbg_addr (dbg_addr),
        .rdata1   (rs1_data),
        .rdata2   (rs2_data),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus writeback control; retirement decisions are made in WB.
    always_comb begin
        state_nxt   = state;
        rf_we       = 1'b0;
        done_nxt    = 1'b0;
        illegal_nxt = 1'b0;
        case (state)
            ST_IDLE:   if (instr_valid) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC:   state_nxt = ST_WB;
            ST_WB: begin
                state_nxt = ST_IDLE;
                if (is_legal_op(instr_q.op)) begin
                    done_nxt = 1'b1;
                    rf_we    = (instr_q.op != OP_NOP);
                end else begin
                    illegal_nxt = 1'b1;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_cin   <= 1'b0;
            cap_y     <= '0;
            cap_flags <= '0;
            flags     <= '0;
            done      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            done    <= done_nxt;
            illegal <= illegal_nxt;
            if (state == ST_IDLE && instr_valid) begin
                instr_q <= decode_instr(instr);
            end
            if (state == ST_DECODE) begin
                alu_a   <= rs1_data;
                alu_b   <= instr_q.use_imm ? DATA_W'(instr_q.imm) : rs2_data;
                alu_op  <= instr_q.op;
                alu_cin <= instr_q.cin_sel ? flags[FLAG_C] : 1'b0;
            end
            if (state == ST_EXEC) begin
                cap_y             <= alu_y;
                cap_flags[FLAG_N] <= alu_n;
                cap_flags[FLAG_Z] <= alu_z;
                cap_flags[FLAG_C] <= alu_c;
                cap_flags[FLAG_V] <= alu_v;
            end
            if (rf_we) begin
                flags <= cap_flags;
            end
        end
    end

`ifdef ALU_SEQ_PERF_CNT_EN
    // Retire count wraps; illegal count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= '0;
            illegal_cnt <= '0;
        end else begin
            if (done_nxt || illegal_nxt) begin
                retired_cnt <= retired_cnt + 16'd1;
            end
            if (illegal_nxt && illegal_cnt != 8'hFF) begin
                illegal_cnt <= illegal_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural 4-bit ALU alongside.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  alu_a, alu_b, alu_op, alu_y;
    logic        alu_cin, alu_n, alu_z, alu_c, alu_v;
    logic        done, illegal;
    logic [3:0]  flags;
    logic [1:0]  dbg_addr;
    logic [3:0]  dbg_data;
`ifdef ALU_SEQ_PERF_CNT_EN
    logic [15:0] retired_cnt;
    logic [7:0]  illegal_cnt;
`endif

    logic        mon_active = 1'b0;
    logic [1:0]  mon_addr = '0;
    logic [1:0]  stim_addr = '0;
    assign dbg_addr = mon_active ? mon_addr : stim_addr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        bit         ill;
        logic [3:0] flg;
        logic [1:0] rd;
        logic [3:0] val;
        int         acc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_cin     (alu_cin),
        .alu_y       (alu_y),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .alu_c       (alu_c),
        .alu_v       (alu_v),
        .done        (done),
        .illegal     (illegal),
        .flags       (flags),
`ifdef ALU_SEQ_PERF_CNT_EN
        .retired_cnt (retired_cnt),
        .illegal_cnt (illegal_cnt),
`endif
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Behavioural ALU: N only on ASR/SUB, C/V only from shifts and add/sub.
    logic [4:0] alu_s;
    always_comb begin
        alu_s = '0;
        alu_y = '0;
        alu_n = 1'b0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_op)
            OP_AND: alu_y = alu_a & alu_b;
            OP_OR:  alu_y = alu_a | alu_b;
            OP_NOT: alu_y = ~alu_a;
            OP_XOR: alu_y = alu_a ^ alu_b;
            OP_SHL: begin alu_y = {alu_a[2:0], 1'b0}; alu_c = alu_a[3]; end
            OP_ASR: begin alu_y = {alu_a[3], alu_a[3:1]}; alu_c = alu_a[0]; alu_n = alu_y[3]; end
            OP_SHR: begin alu_y = {1'b0, alu_a[3:1]}; alu_c = alu_a[0]; end
            OP_ADD: begin
                alu_s = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
                alu_y = alu_s[3:0];
                alu_c = alu_s[4];
                alu_v = (alu_a[3] == alu_b[3]) && (alu_y[3] != alu_a[3]);
            end
            OP_SUB: begin
                alu_s = {1'b0, alu_a} - {1'b0, alu_b} - {4'b0, alu_cin};
                alu_y = alu_s[3:0];
                alu_c = alu_s[4];
                alu_v = (alu_a[3] != alu_b[3]) && (alu_y[3] != alu_a[3]);
                alu_n = alu_y[3];
            end
            default: alu_y = '0;
        endcase
    end
    assign alu_z = (alu_y == 4'd0);

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2,
                                        input logic ui, input logic cs, input logic [3:0] imm);
        return {op, rd, rs1, rs2, ui, cs, imm};
    endfunction

    // Retirement monitor: pops an expectation on every done/illegal pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done || illegal) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {14'd0, done, illegal}, 16'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", {14'd0, done, illegal}, e.ill ? 16'd1 : 16'd2);
                    chk("latency", 16'(cyc - e.acc), 16'd3);
                    chk("flags", {12'd0, flags}, {12'd0, e.flg});
                    mon_addr   = e.rd;
                    mon_active = 1'b1;
                    #1;
                    chk("regfile", {12'd0, dbg_data}, {12'd0, e.val});
                    mon_active = 1'b0;
                end
            end
        end
    end

    // Present an instruction, wait (bounded) for acceptance, return at the next negedge.
    task automatic issue(input logic [15:0] ins, input bit ill, input logic [3:0] flg,
                         input logic [1:0] rd, input logic [3:0] val, input bit keep,
                         input bit track, output int waits, output int acc);
        exp_t e;
        instr       = ins;
        instr_valid = 1'b1;
        waits       = 0;
        while (!instr_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 20) chk("accept_timeout", 16'd0, 16'd1);
        acc = cyc + 1;
        if (track) begin
            e.ill = ill; e.flg = flg; e.rd = rd; e.val = val; e.acc = acc;
            sb.push_back(e);
        end
        @(negedge clk);
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((sb.size() != 0 || !instr_ready) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) chk("idle_timeout", 16'd0, 16'd1);
        @(negedge clk);
    endtask

    initial begin
        int n, a0, a1, a2;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {15'd0, instr_ready}, 16'd1);
        chk("rst_flags", {12'd0, flags}, 16'd0);
        chk("rst_alu", {3'd0, alu_a, alu_b, alu_op, alu_cin}, 16'd0);
        chk("rst_pulse", {14'd0, done, illegal}, 16'd0);
`ifdef ALU_SEQ_PERF_CNT_EN
        chk("rst_retired", retired_cnt, 16'd0);
`endif

        issue(enc(OP_OR, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 4'h5), 0, 4'b0000, 2'd1, 4'h5, 0, 1, n, a0);
        wait_idle();
        issue(enc(OP_OR, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 4'hF), 0, 4'b0000, 2'd1, 4'hF, 0, 1, n, a0);
        issue(enc(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 1'b0, 4'h1), 0, 4'b0110, 2'd2, 4'h0, 0, 1, n, a0);
        issue(enc(OP_ADD, 2'd3, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0), 0, 4'b0000, 2'd3, 4'h1, 0, 1, n, a0);
        @(negedge clk);
        chk("exec_cin", {15'd0, alu_cin}, 16'd1);
        chk("exec_op", {12'd0, alu_op}, {12'd0, OP_ADD});
        wait_idle();

        issue(enc(OP_OR, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 4'h5), 0, 4'b0000, 2'd1, 4'h5, 0, 1, n, a0);
        issue(enc(OP_SUB, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 4'h0), 0, 4'b0100, 2'd1, 4'h0, 0, 1, n, a0);
        issue(enc(4'hC, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 4'h0), 1, 4'b0100, 2'd3, 4'h1, 0, 1, n, a0);
        issue(16'h0C00, 0, 4'b0100, 2'd3, 4'h1, 0, 1, n, a0);
        wait_idle();

        // Valid held high across three dependent instructions.
        issue(enc(OP_OR, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 4'hA), 0, 4'b0000, 2'd1, 4'hA, 1, 1, n, a0);
        issue(enc(OP_ADD, 2'd2, 2'd1, 2'd1, 1'b0, 1'b0, 4'h0), 0, 4'b0011, 2'd2, 4'h4, 1, 1, n, a1);
        chk("ready_low_cycles", 16'(n), 16'd3);
        chk("accept_spacing1", 16'(a1 - a0), 16'd4);
        issue(enc(OP_XOR, 2'd3, 2'd2, 2'd0, 1'b1, 1'b0, 4'h4), 0, 4'b0100, 2'd3, 4'h0, 0, 1, n, a2);
        chk("accept_spacing2", 16'(a2 - a1), 16'd4);
        wait_idle();
`ifdef ALU_SEQ_PERF_CNT_EN
        chk("retired_cnt", retired_cnt, 16'd11);
        chk("illegal_cnt", {8'd0, illegal_cnt}, 16'd1);
`endif

        // Reset during EXEC abandons the instruction.
        issue(enc(OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 1'b0, 4'h1), 0, 4'b0000, 2'd1, 4'h0, 0, 0, n, a0);
        @(negedge clk);
        chk("pre_rst_exec_a", {12'd0, alu_a}, 16'hA);
        rst = 1'b1;
        #1;
        chk("midrst_alu", {3'd0, alu_a, alu_b, alu_op, alu_cin}, 16'd0);
        chk("midrst_flags", {12'd0, flags}, 16'd0);
        chk("midrst_pulse", {14'd0, done, illegal}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {15'd0, instr_ready}, 16'd1);
        stim_addr = 2'd1;
        #1;
        chk("post_rst_r1", {12'd0, dbg_data}, 16'd0);
`ifdef ALU_SEQ_PERF_CNT_EN
        chk("post_rst_retired", retired_cnt, 16'd0);
`endif
        repeat (6) @(negedge clk);
        chk("sb_empty", 16'(sb.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
